cp0_ctrl: RTL and testbench
===========================

CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 Parameter N_HWINT, default 6, number of hardware interrupt lines (1..6), mapped to Cause/Status bits 10..10+N_HWINT-1.
REQ-002 Parameter CNT_DIV, default 2, clk cycles per Count increment (1..16).
REQ-003 Parameter EXC_VEC, default 32'hBFC00380, exception entry address.
REQ-004 clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-005 wb_valid  in  1  WB-stage instruction valid.
REQ-006 fetch_error, inst_reserved, syscall, brk, overflow, raddr_error, waddr_error  in  1 each  exception flags of the WB instruction.
REQ-007 eret  in  1  WB instruction is ERET; mtc0  in  1  write CP0.
REQ-008 cp0_addr  in  8  {reg[4:0], sel[2:0]}; wdata  in  32  MTC0 data.
REQ-009 pc  in  32; dm_addr  in  32; delay_slot  in  1  WB instruction attributes.
REQ-010 hw_int  in  N_HWINT  asynchronous level interrupt requests.
REQ-011 rdata  out  32  combinational CP0 read data for cp0_addr (BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14; else 0).
REQ-012 exc_valid  out  1; exc_pc  out  32; cancel  out  1  flush of younger stages (equals exc_valid).
REQ-013 timer_int  out  1  Cause[30].

Function
REQ-014 All events qualify with wb_valid; with wb_valid=0 no CP0 register changes except Count, Cause[30], Cause IP bits.
REQ-015 Priority per cycle: interrupt > fetch_error > inst_reserved > syscall > brk > overflow > raddr_error > waddr_error > eret > mtc0.
REQ-016 ExcCode: Int 0, AdEL 4 (fetch_error, raddr_error), AdES 5, Sys 8, Bp 9, RI 10, Ov 12; written to Cause[6:2] only for the winning event.
REQ-017 Exception/interrupt taken: Status.EXL<=1, Cause.BD<=delay_slot, EPC<=delay_slot ? pc-4 : pc (32-bit wrap), exc_pc=EXC_VEC, exc_valid=1 same cycle.
REQ-018 BadVAddr<=pc on fetch_error winner; <=dm_addr on raddr/waddr winner; otherwise held.
REQ-019 eret winner: exc_valid=1, exc_pc=EPC, Status.EXL<=0 next edge.
REQ-020 Any exception, interrupt or eret suppresses mtc0 in that cycle.
REQ-021 hw_int passes a two-flop synchroniser per line; synchronised value written to Cause[10+i] every cycle (2-cycle latency).
REQ-022 int_pending register <= Status.IE & !Status.EXL & |(Status.IM & Cause.IP) each cycle; interrupt taken when int_pending & wb_valid, latency 1 cycle from condition.
REQ-023 Prescaler counts 0..CNT_DIV-1 and wraps; Count increments (mod 2^32) on wrap.
REQ-024 Compare match checked only on increment cycles using new Count value; match sets Cause[30] and Cause[15].
REQ-025 mtc0 to Compare clears Cause[30] and Cause[15]; clear wins over simultaneous match.
REQ-026 mtc0 to Count loads wdata, resets prescaler, overrides simultaneous increment.
REQ-027 mtc0 writable fields: Status all bits; Cause[9:8] only; EPC, Count, Compare full; BadVAddr read-only.
REQ-028 Reset mid-operation aborts any pending interrupt; int_pending and synchronisers cleared.

Reset
REQ-029 On reset: Status=32'h0040_0000 (BEV=1), Cause=0, Count=0, Compare=32'hFFFF_FFFF, prescaler=0, int_pending=0, synchronisers=0; EPC, BadVAddr=0.
REQ-030 During reset exc_valid=0, cancel=0, timer_int=0.

Structure
REQ-031 Package cp0_pkg holds CP0 register address constants, ExcCode constants, EXC_VEC default, Status/Cause bit positions.
REQ-032 One sub-module cp0_timer: prescaler, Count, Compare, match logic, Cause[30]/[15] flag.

Verification
REQ-033 syscall, wb_valid=1, pc=32'h8000_1000, delay_slot=1 -> exc_pc=BFC00380, EPC=8000_0FFC, Cause.BD=1, ExcCode=8, EXL=1.
REQ-034 Status=32'h0000_8001, Compare=20, CNT_DIV=2 -> Cause[30] set 40 cycles after reset release, interrupt taken next valid cycle, ExcCode=0.
REQ-035 overflow and raddr_error together, dm_addr=32'h0000_0003 -> ExcCode=12, BadVAddr unchanged.
REQ-036 mtc0 Compare write in match cycle -> Cause[30]=0 after edge; no interrupt.
REQ-037 EXL=1, eret with EPC=32'h8000_2000 -> exc_pc=8000_2000, EXL=0 next cycle.
REQ-038 hw_int[0] pulse with IM2=1, IE=1 -> Cause[10]=1 after 2 cycles, interrupt taken cycle 3; reset asserted cycle 2 -> no exc_valid.

Source files
------------

// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 controller: register addresses in the
// {reg[4:0], sel[2:0]} encoding, exception codes, the default exception
// vector, Status/Cause bit positions and the per-cycle event encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cp0_pkg;

   // CP0 register addresses, {reg, sel} with sel = 0
   localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC0_0380;
   localparam logic [31:0] STATUS_RESET    = 32'h0040_0000;  // BEV = 1

   // Status bit positions
   localparam int STATUS_IE     = 0;
   localparam int STATUS_EXL    = 1;
   localparam int STATUS_IM_LSB = 8;

   // Cause bit positions
   localparam int CAUSE_BD       = 31;
   localparam int CAUSE_TI       = 30;
   localparam int CAUSE_IP_LSB   = 8;
   localparam int CAUSE_HWIP_LSB = 10;
   localparam int CAUSE_TIMER_IP = 15;
   localparam int CAUSE_EXC_LSB  = 2;

   // Winning WB-stage event, listed from highest to lowest priority
   typedef enum logic [3:0] {
      EV_NONE,
      EV_INT,
      EV_ADEL_FETCH,
      EV_RI,
      EV_SYS,
      EV_BP,
      EV_OV,
      EV_ADEL_LOAD,
      EV_ADES,
      EV_ERET,
      EV_MTC0
   } cp0_event_e;

   function automatic logic [4:0] exc_code_of(input cp0_event_e ev);
      logic [4:0] code;
      case (ev)
         EV_ADEL_FETCH, EV_ADEL_LOAD: code = EXC_ADEL;
         EV_ADES:                     code = EXC_ADES;
         EV_SYS:                      code = EXC_SYS;
         EV_BP:                       code = EXC_BP;
         EV_RI:                       code = EXC_RI;
         EV_OV:                       code = EXC_OV;
         default:                     code = EXC_INT;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer. A prescaler divides clk by CNT_DIV; Count advances on
// each prescaler wrap. A match against Compare is checked only on increment
// cycles, using the incremented Count, and sets a sticky timer flag that is
// cleared by a Compare write.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   count_we    in   load Count from wdata (also restarts the prescaler)
//   compare_we  in   load Compare from wdata, clear the timer flag
//   wdata       in   32-bit write data
//   count       out  Count register
//   compare     out  Compare register
//   timer_flag  out  sticky match flag (Cause[30] / Cause[15])
// -----------------------------------------------------------------------------
module cp0_timer #(
   parameter int CNT_DIV = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_flag
);

   localparam int             PW        = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(CNT_DIV - 1);

   logic [PW-1:0] presc;
   logic          tick;
   logic [31:0]   count_inc;

   assign tick      = (presc == PRESC_MAX);
   assign count_inc = count + 32'd1;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values; reset is synchronous, so it lives inside
   // the clocked block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc      <= '0;
         count      <= '0;
         compare    <= 32'hFFFF_FFFF;
         timer_flag <= 1'b0;
      end else begin
         // A Count load overrides the increment and restarts the prescaler.
         if (count_we) begin
            count <= wdata;
            presc <= '0;
         end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) count <= count_inc;
         end

         // Compare write clears the flag and wins over a match in the same cycle.
         if (compare_we) begin
            compare    <= wdata;
            timer_flag <= 1'b0;
         end else if (tick && !count_we && (count_inc == compare)) begin
            timer_flag <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl
// MIPS-style CP0 controller for the WB stage: exception/interrupt priority,
// Status/Cause/EPC/BadVAddr registers, ERET, MTC0 writes, hardware interrupt
// synchronisers and the Count/Compare timer (cp0_timer).
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   wb_valid              WB-stage instruction valid (qualifies every event)
//   fetch_error .. waddr_error  exception flags of the WB instruction
//   eret, mtc0            ERET / move-to-CP0 in WB
//   cp0_addr [7:0]        {reg, sel} for reads and MTC0 writes
//   wdata [31:0]          MTC0 write data
//   pc, dm_addr [31:0]    WB instruction PC and data address
//   delay_slot            WB instruction sits in a branch delay slot
//   hw_int [N_HWINT-1:0]  asynchronous level interrupt requests
//   rdata [31:0]          combinational read of cp0_addr
//   exc_valid, cancel     redirect / flush of younger stages
//   exc_pc [31:0]         redirect target (EXC_VEC or EPC)
//   timer_int             Cause[30]
// -----------------------------------------------------------------------------
module cp0_ctrl
   import cp0_pkg::*;
#(
   parameter int          N_HWINT = 6,
   parameter int          CNT_DIV = 2,
   parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wb_valid,
   input  logic               fetch_error,
   input  logic               inst_reserved,
   input  logic               syscall,
   input  logic               brk,
   input  logic               overflow,
   input  logic               raddr_error,
   input  logic               waddr_error,
   input  logic               eret,
   input  logic               mtc0,
   input  logic [7:0]         cp0_addr,
   input  logic [31:0]        wdata,
   input  logic [31:0]        pc,
   input  logic [31:0]        dm_addr,
   input  logic               delay_slot,
   input  logic [N_HWINT-1:0] hw_int,
   output logic [31:0]        rdata,
   output logic               exc_valid,
   output logic [31:0]        exc_pc,
   output logic               cancel,
   output logic               timer_int
);

   logic [31:0]        status;
   logic [31:0]        epc;
   logic [31:0]        badvaddr;
   logic               bd;
   logic [4:0]         exccode;
   logic [1:0]         sw_ip;
   logic [N_HWINT-1:0] sync1;
   logic [N_HWINT-1:0] sync2;
   logic               int_pending;

   logic [31:0]        count;
   logic [31:0]        compare;
   logic               timer_flag;

   cp0_event_e         ev;
   logic               is_exc;
   logic               is_eret;
   logic               is_mtc0;
   logic [7:0]         ip;
   logic [31:0]        cause_value;

   // NOTE: every signal driven here gets a default first, so no path through
   // the if-chain can leave it unassigned and infer a latch.
   always_comb begin
      ev = EV_NONE;
      if (wb_valid) begin
         if      (int_pending)   ev = EV_INT;
         else if (fetch_error)   ev = EV_ADEL_FETCH;
         else if (inst_reserved) ev = EV_RI;
         else if (syscall)       ev = EV_SYS;
         else if (brk)           ev = EV_BP;
         else if (overflow)      ev = EV_OV;
         else if (raddr_error)   ev = EV_ADEL_LOAD;
         else if (waddr_error)   ev = EV_ADES;
         else if (eret)          ev = EV_ERET;
         else if (mtc0)          ev = EV_MTC0;
      end
   end

   assign is_eret = (ev == EV_ERET);
   assign is_mtc0 = (ev == EV_MTC0);
   assign is_exc  = (ev != EV_NONE) && !is_eret && !is_mtc0;

   assign exc_valid = !reset && (is_exc || is_eret);
   assign cancel    = exc_valid;
   assign exc_pc    = is_eret ? epc : EXC_VEC;
   assign timer_int = !reset && timer_flag;

   // Pending-interrupt vector as seen in Cause[15:8]. Hardware line 5 and the
   // timer share IP7 (Cause[15]), so that bit is their OR.
   always_comb begin
      ip        = '0;
      ip[1:0]   = sw_ip;
      for (int i = 0; i < N_HWINT; i++) begin
         ip[CAUSE_HWIP_LSB - CAUSE_IP_LSB + i] = sync2[i];
      end
      ip[CAUSE_TIMER_IP - CAUSE_IP_LSB] = ip[CAUSE_TIMER_IP - CAUSE_IP_LSB] | timer_flag;
   end

   always_comb begin
      cause_value                        = '0;
      cause_value[CAUSE_BD]              = bd;
      cause_value[CAUSE_TI]              = timer_flag;
      cause_value[CAUSE_IP_LSB +: 8]     = ip;
      cause_value[CAUSE_EXC_LSB +: 5]    = exccode;
   end

   always_comb begin
      rdata = '0;
      case (cp0_addr)
         CP0_BADVADDR: rdata = badvaddr;
         CP0_COUNT:    rdata = count;
         CP0_COMPARE:  rdata = compare;
         CP0_STATUS:   rdata = status;
         CP0_CAUSE:    rdata = cause_value;
         CP0_EPC:      rdata = epc;
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status      <= STATUS_RESET;
         epc         <= '0;
         badvaddr    <= '0;
         bd          <= 1'b0;
         exccode     <= '0;
         sw_ip       <= '0;
         sync1       <= '0;
         sync2       <= '0;
         int_pending <= 1'b0;
      end else begin
         sync1 <= hw_int;
         sync2 <= sync1;

         // An exception taken now sets EXL at this same edge; dropping the
         // pending bit stops a second interrupt from firing in the one cycle
         // before the new EXL is reflected in the condition.
         int_pending <= status[STATUS_IE] && !status[STATUS_EXL]
                        && |(status[STATUS_IM_LSB +: 8] & ip) && !is_exc;

         if (is_exc) begin
            status[STATUS_EXL] <= 1'b1;
            bd                 <= delay_slot;
            epc                <= delay_slot ? pc - 32'd4 : pc;
            exccode            <= exc_code_of(ev);
            if (ev == EV_ADEL_FETCH) begin
               badvaddr <= pc;
            end else if (ev == EV_ADEL_LOAD || ev == EV_ADES) begin
               badvaddr <= dm_addr;
            end
         end else if (is_eret) begin
            status[STATUS_EXL] <= 1'b0;
         end else if (is_mtc0) begin
            case (cp0_addr)
               CP0_STATUS: status <= wdata;
               CP0_CAUSE:  sw_ip  <= wdata[CAUSE_IP_LSB +: 2];
               CP0_EPC:    epc    <= wdata;
               default:    ;
            endcase
         end
      end
   end

   cp0_timer #(
      .CNT_DIV (CNT_DIV)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (is_mtc0 && (cp0_addr == CP0_COUNT)),
      .compare_we (is_mtc0 && (cp0_addr == CP0_COMPARE)),
      .wdata      (wdata),
      .count      (count),
      .compare    (compare),
      .timer_flag (timer_flag)
   );

endmodule

// File: tb/tb_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_ctrl
// Self-checking bench for cp0_ctrl. A behavioural model tracks the CP0
// architectural state (Count as load value plus elapsed cycles / CNT_DIV,
// interrupt lines as a two-deep history) and a negedge process compares every
// DUT output and the read port against it. Directed scenarios pin the model
// with literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_cp0_ctrl;

   localparam int          N_HWINT = 6;
   localparam int          CNT_DIV = 2;
   localparam logic [31:0] VEC     = 32'hBFC0_0380;

   localparam logic [7:0] A_BADV = 8'h40;
   localparam logic [7:0] A_CNT  = 8'h48;
   localparam logic [7:0] A_CMP  = 8'h58;
   localparam logic [7:0] A_STAT = 8'h60;
   localparam logic [7:0] A_CAUS = 8'h68;
   localparam logic [7:0] A_EPC  = 8'h70;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               wb_valid = 1'b0;
   logic               fetch_error = 1'b0, inst_reserved = 1'b0, syscall = 1'b0, brk = 1'b0;
   logic               overflow = 1'b0, raddr_error = 1'b0, waddr_error = 1'b0;
   logic               eret = 1'b0, mtc0 = 1'b0, delay_slot = 1'b0;
   logic [7:0]         cp0_addr = '0;
   logic [31:0]        wdata = '0, pc = '0, dm_addr = '0;
   logic [N_HWINT-1:0] hw_int = '0;
   logic [31:0]        rdata, exc_pc;
   logic               exc_valid, cancel, timer_int;

   always #5 clk = ~clk;

   cp0_ctrl #(
      .N_HWINT (N_HWINT),
      .CNT_DIV (CNT_DIV),
      .EXC_VEC (VEC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .fetch_error   (fetch_error),
      .inst_reserved (inst_reserved),
      .syscall       (syscall),
      .brk           (brk),
      .overflow      (overflow),
      .raddr_error   (raddr_error),
      .waddr_error   (waddr_error),
      .eret          (eret),
      .mtc0          (mtc0),
      .cp0_addr      (cp0_addr),
      .wdata         (wdata),
      .pc            (pc),
      .dm_addr       (dm_addr),
      .delay_slot    (delay_slot),
      .hw_int        (hw_int),
      .rdata         (rdata),
      .exc_valid     (exc_valid),
      .exc_pc        (exc_pc),
      .cancel        (cancel),
      .timer_int     (timer_int)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0]        m_status, m_epc, m_badv, m_load, m_compare;
   logic               m_bd, m_ti, m_pend;
   logic [4:0]         m_code;
   logic [1:0]         m_swip;
   int                 m_since;
   logic [N_HWINT-1:0] hist [2];   // [0] = sampled last edge, [1] = two edges ago
   bit                 m_ok = 1'b0;

   function automatic logic [31:0] m_count();
      return m_load + 32'(m_since / CNT_DIV);
   endfunction

   function automatic logic [7:0] m_ip();
      logic [7:0] v;
      v = {6'b0, m_swip};
      for (int i = 0; i < N_HWINT; i++) v[2+i] = hist[1][i];
      v[7] = v[7] | m_ti;
      return v;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      case (a)
         A_BADV:  return m_badv;
         A_CNT:   return m_count();
         A_CMP:   return m_compare;
         A_STAT:  return m_status;
         A_CAUS:  return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
         A_EPC:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   // Index of the winning request in priority order, -1 if none:
   // 0 int, 1 fetch, 2 RI, 3 sys, 4 bp, 5 ov, 6 raddr, 7 waddr, 8 eret, 9 mtc0
   function automatic int m_winner();
      logic [9:0] r;
      r = {mtc0, eret, waddr_error, raddr_error, overflow, brk, syscall,
           inst_reserved, fetch_error, m_pend};
      if (!wb_valid) return -1;
      for (int i = 0; i < 10; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic logic [4:0] code_of(input int w);
      case (w)
         0:       return 5'd0;
         1:       return 5'd4;
         2:       return 5'd10;
         3:       return 5'd8;
         4:       return 5'd9;
         5:       return 5'd12;
         6:       return 5'd4;
         default: return 5'd5;
      endcase
   endfunction

   always @(posedge clk) begin : model_update
      int         w;
      logic [7:0] ipn;
      logic       cnt_we, cmp_we, pend_next;
      if (reset) begin
         m_status  = 32'h0040_0000;
         m_epc     = '0;
         m_badv    = '0;
         m_bd      = 1'b0;
         m_code    = '0;
         m_swip    = '0;
         m_load    = '0;
         m_since   = 0;
         m_compare = 32'hFFFF_FFFF;
         m_ti      = 1'b0;
         m_pend    = 1'b0;
         hist[0]   = '0;
         hist[1]   = '0;
         m_ok      = 1'b1;
      end else if (m_ok) begin
         w         = m_winner();
         ipn       = m_ip();
         cnt_we    = (w == 9) && (cp0_addr == A_CNT);
         cmp_we    = (w == 9) && (cp0_addr == A_CMP);
         pend_next = m_status[0] && !m_status[1] && (|(m_status[15:8] & ipn))
                     && !(w >= 0 && w <= 7);
         if (cnt_we) begin
            m_load  = wdata;
            m_since = 0;
         end else begin
            m_since++;
            if ((m_since % CNT_DIV == 0) && (m_count() == m_compare) && !cmp_we) m_ti = 1'b1;
         end
         if (cmp_we) begin
            m_compare = wdata;
            m_ti      = 1'b0;
         end
         if (w >= 0 && w <= 7) begin
            m_status[1] = 1'b1;
            m_bd        = delay_slot;
            m_epc       = delay_slot ? pc - 32'd4 : pc;
            m_code      = code_of(w);
            if (w == 1) m_badv = pc;
            else if (w == 6 || w == 7) m_badv = dm_addr;
         end else if (w == 8) begin
            m_status[1] = 1'b0;
         end else if (w == 9) begin
            case (cp0_addr)
               A_STAT:  m_status = wdata;
               A_CAUS:  m_swip   = wdata[9:8];
               A_EPC:   m_epc    = wdata;
               default: ;
            endcase
         end
         m_pend  = pend_next;
         hist[1] = hist[0];
         hist[0] = hw_int;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin : compare_outputs
      int   w;
      logic redirect;
      if (reset) begin
         check("reset_exc_valid", 32'(exc_valid), 32'd0);
         check("reset_cancel",    32'(cancel),    32'd0);
         check("reset_timer_int", 32'(timer_int), 32'd0);
      end else if (m_ok) begin
         w        = m_winner();
         redirect = (w >= 0 && w <= 8);
         check("exc_valid", 32'(exc_valid), 32'(redirect));
         check("cancel",    32'(cancel),    32'(redirect));
         if (w >= 0 && w <= 7) check("exc_pc_vec", exc_pc, VEC);
         else if (w == 8)      check("exc_pc_eret", exc_pc, m_epc);
         check("timer_int", 32'(timer_int), 32'(m_ti));
         check("rdata", rdata, m_read(cp0_addr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wb_valid = 0; fetch_error = 0; inst_reserved = 0; syscall = 0; brk = 0;
      overflow = 0; raddr_error = 0; waddr_error = 0; eret = 0; mtc0 = 0;
      delay_slot = 0; cp0_addr = '0; wdata = '0; pc = '0; dm_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [7:0] a, output logic [31:0] d);
      cp0_addr = a;
      #1;
      d = rdata;
   endtask

   task automatic do_mtc0(input logic [7:0] a, input logic [31:0] d);
      idle();
      wb_valid = 1; mtc0 = 1; cp0_addr = a; wdata = d;
      tick();
      idle();
   endtask

   task automatic do_reset();
      idle();
      hw_int = '0;
      reset  = 1;
      tick();
      tick();
      reset  = 0;
   endtask

   // Timer interrupt after 40 cycles, or its suppression by a Compare write
   // landing in the match cycle.
   task automatic timer_scenario(input bit clear_in_match);
      logic [31:0] d;
      do_reset();
      do_mtc0(A_STAT, 32'h0000_8001);       // edge 1
      do_mtc0(A_CMP, 32'd20);               // edge 2
      repeat (37) tick();                   // edges 3..39
      check("timer_before_match", 32'(timer_int), 32'd0);
      if (clear_in_match) do_mtc0(A_CMP, 32'd100);
      else                tick();           // edge 40
      check("timer_at_match", 32'(timer_int), clear_in_match ? 32'd0 : 32'd1);
      if (!clear_in_match) begin
         peek(A_CNT, d);
         check("count_at_match", d, 32'd20);
         cp0_addr = '0;
      end
      tick();                               // edge 41: pending registers
      wb_valid = 1; pc = 32'h8000_0100;
      #1;
      check("timer_irq_taken", 32'(exc_valid), clear_in_match ? 32'd0 : 32'd1);
      tick();
      idle();
      if (!clear_in_match) begin
         peek(A_CAUS, d);
         check("timer_irq_code", 32'(d[6:2]), 32'd0);
         check("timer_irq_ti",   32'(d[30]),  32'd1);
      end
   endtask

   // hw_int[0] pulse through the synchroniser, optionally killed by reset.
   task automatic hw_scenario(input bit reset_mid);
      logic [31:0] d;
      do_reset();
      do_mtc0(A_STAT, 32'h0000_0401);
      hw_int = 6'b000001;
      tick();                               // sync stage 1
      hw_int = '0;
      if (reset_mid) reset = 1;
      tick();                               // sync stage 2 (or reset)
      reset = 0;
      if (reset_mid) begin
         for (int i = 0; i < 4; i++) begin
            wb_valid = 1;
            #1;
            check("hw_reset_no_exc", 32'(exc_valid), 32'd0);
            tick();
         end
         idle();
      end else begin
         peek(A_CAUS, d);
         check("hw_cause_ip2", 32'(d[10]), 32'd1);
         cp0_addr = '0;
         tick();                            // pending registers
         wb_valid = 1; pc = 32'h8000_0200;
         #1;
         check("hw_irq_taken", 32'(exc_valid), 32'd1);
         check("hw_irq_vec", exc_pc, VEC);
         tick();
         idle();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] d;
      idle();
      reset = 1;
      tick(); tick(); tick();
      reset = 0;

      // reset values
      peek(A_STAT, d); check("reset_status",  d, 32'h0040_0000);
      peek(A_CMP,  d); check("reset_compare", d, 32'hFFFF_FFFF);
      peek(A_CAUS, d); check("reset_cause",   d, 32'h0000_0000);
      tick();

      // syscall in a delay slot
      idle();
      wb_valid = 1; syscall = 1; pc = 32'h8000_1000; delay_slot = 1;
      #1;
      check("sys_exc_valid", 32'(exc_valid), 32'd1);
      check("sys_exc_pc",    exc_pc, 32'hBFC0_0380);
      tick();
      idle();
      peek(A_EPC,  d); check("sys_epc", d, 32'h8000_0FFC);
      peek(A_CAUS, d); check("sys_bd", 32'(d[31]), 32'd1); check("sys_code", 32'(d[6:2]), 32'd8);
      peek(A_STAT, d); check("sys_exl", 32'(d[1]), 32'd1);
      tick();

      // fetch error loads BadVAddr; overflow then beats raddr_error
      idle();
      wb_valid = 1; fetch_error = 1; pc = 32'h0000_1234;
      tick();
      idle();
      peek(A_BADV, d); check("fetch_badv", d, 32'h0000_1234);
      wb_valid = 1; overflow = 1; raddr_error = 1; dm_addr = 32'h0000_0003;
      tick();
      idle();
      peek(A_CAUS, d); check("ov_code", 32'(d[6:2]), 32'd12);
      peek(A_BADV, d); check("ov_badv_held", d, 32'h0000_1234);
      tick();

      // eret returns to EPC and clears EXL
      do_mtc0(A_STAT, 32'h0000_0002);
      do_mtc0(A_EPC,  32'h8000_2000);
      wb_valid = 1; eret = 1; mtc0 = 1; cp0_addr = A_EPC; wdata = 32'h1111_1111;
      #1;
      check("eret_exc_valid", 32'(exc_valid), 32'd1);
      check("eret_exc_pc",    exc_pc, 32'h8000_2000);
      tick();
      idle();
      peek(A_STAT, d); check("eret_exl", 32'(d[1]), 32'd0);
      peek(A_EPC,  d); check("eret_blocks_mtc0", d, 32'h8000_2000);
      tick();

      timer_scenario(1'b0);
      timer_scenario(1'b1);
      hw_scenario(1'b0);
      hw_scenario(1'b1);

      // randomized phase
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         reset         = ($urandom_range(0, 399) == 0);
         wb_valid      = ($urandom_range(0, 3) != 0);
         fetch_error   = ($urandom_range(0, 24) == 0);
         inst_reserved = ($urandom_range(0, 24) == 0);
         syscall       = ($urandom_range(0, 24) == 0);
         brk           = ($urandom_range(0, 24) == 0);
         overflow      = ($urandom_range(0, 24) == 0);
         raddr_error   = ($urandom_range(0, 24) == 0);
         waddr_error   = ($urandom_range(0, 24) == 0);
         eret          = ($urandom_range(0, 9) == 0);
         mtc0          = ($urandom_range(0, 2) == 0);
         delay_slot    = 1'($urandom);
         pc            = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
         dm_addr       = $urandom;
         case ($urandom_range(0, 6))
            0:       cp0_addr = A_BADV;
            1:       cp0_addr = A_CNT;
            2:       cp0_addr = A_CMP;
            3:       cp0_addr = A_STAT;
            4:       cp0_addr = A_CAUS;
            5:       cp0_addr = A_EPC;
            default: cp0_addr = 8'($urandom);
         endcase
         wdata = $urandom;
         if (cp0_addr == A_CMP && $urandom_range(0, 1) == 1)
            wdata = m_count() + 32'($urandom_range(0, 8));
         if (cp0_addr == A_CNT && $urandom_range(0, 1) == 1)
            wdata = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         if (cp0_addr == A_STAT && $urandom_range(0, 1) == 1)
            wdata = {16'h0, 8'($urandom), 6'h0, 1'b0, 1'b1};
         if ($urandom_range(0, 7) == 0) hw_int = N_HWINT'($urandom);
         tick();
      end
      reset = 0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
